// File: rtl/mem_unloader_pkg.sv
// Shared definitions for the result-matrix unloader: bus widths, memory
// direction encodings and the controller state type.
package mem_unloader_pkg;

  localparam int unsigned DEF_DATA_W = 256;
  localparam int unsigned DEF_ELEM_W = 16;
  localparam int unsigned DEF_N_ELEM = 16;
  localparam int unsigned DEF_ADDR_W = 3;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_EMIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mem_unloader_word_serializer.sv
// Holds one memory word and emits its elements LSB-first under valid/ready,
// flagging the transfer of the final element back to the controller.
module mem_unloader_word_serializer #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ELEM_W = 16,
  parameter int unsigned N_ELEM = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ELEM_W-1:0] out_data,
  output logic              last
);

  localparam int unsigned IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  logic [DATA_W-1:0] sreg_q;
  logic [IDX_W-1:0]  idx_q;
  logic              valid_q;
  logic              xfer;

  assign xfer      = valid_q && out_ready;
  assign last      = xfer && (idx_q == IDX_W'(N_ELEM - 1));
  assign out_valid = valid_q;
  // Shifting keeps the current element in the low slice, so no wide mux.
  assign out_data  = sreg_q[ELEM_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      sreg_q  <= word;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (xfer) begin
      sreg_q  <= sreg_q >> ELEM_W;
      idx_q   <= idx_q + 1'b1;
      if (last) valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_unloader.sv
// Memory-read master: fetches a run of words over the shared bus and streams
// their elements out; the bus is released while elements are being emitted.
module mem_unloader
  import mem_unloader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ELEM_W = DEF_ELEM_W,
  parameter int unsigned N_ELEM = DEF_N_ELEM,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_cnt,
  output logic              busy,
  output logic              done,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              m_en,
  output logic              m_rw,
  output logic [ADDR_W-1:0] m_address,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   left_q;
  logic [1:0]        lat_q;
  logic              zero_done_q;
  logic              load;
  logic              last;
  logic              accept;

  assign accept    = (state_q == ST_IDLE) && start && (word_cnt != '0);
  assign m_rw      = MEM_READ;
  assign m_address = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    bus_req = 1'b0;
    m_en    = 1'b0;
    load    = 1'b0;
    busy    = (state_q != ST_IDLE);
    done    = zero_done_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          m_en    = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_q == 2'(RD_LAT - 1)) begin
          load    = 1'b1;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (last) state_d = (left_q == {{ADDR_W{1'b0}}, 1'b1}) ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      left_q      <= '0;
      lat_q       <= '0;
      zero_done_q <= 1'b0;
    end else begin
      // A zero-length request completes without ever leaving IDLE.
      zero_done_q <= (state_q == ST_IDLE) && start && (word_cnt == '0);
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q <= base_addr;
            left_q <= word_cnt;
          end
        end
        ST_REQ:  lat_q <= '0;
        ST_WAIT: lat_q <= lat_q + 1'b1;
        ST_EMIT: begin
          if (last) begin
            left_q <= left_q - 1'b1;
            addr_q <= addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  mem_unloader_word_serializer #(
    .DATA_W (DATA_W),
    .ELEM_W (ELEM_W),
    .N_ELEM (N_ELEM)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .word      (m_rdata),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .last      (last)
  );

endmodule

// File: tb/tb_mem_unloader.sv
// Scoreboard bench for mem_unloader: expected addresses and elements are
// queued at stimulus time and retired by a free-running monitor.
module tb_mem_unloader;

  localparam int DW = 256;
  localparam int EW = 16;
  localparam int NE = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_cnt = '0;
  logic          busy, done, bus_req, m_en, m_rw;
  logic          bus_gnt = 1'b1;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_rdata = '0;
  logic [EW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;

  always #5 clk = ~clk;

  mem_unloader #(
    .DATA_W (DW),
    .ELEM_W (EW),
    .N_ELEM (NE),
    .ADDR_W (AW),
    .RD_LAT (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .busy      (busy),
    .done      (done),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .m_en      (m_en),
    .m_rw      (m_rw),
    .m_address (m_address),
    .m_rdata   (m_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  logic [DW-1:0] mem [8];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int req_cnt = 0;
  logic [EW-1:0] exp_q [$];
  logic [AW-1:0] addr_exp_q [$];
  logic bp_en = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int n;

  // Word 2 holds element k = k; other words carry A, address and index.
  function automatic logic [EW-1:0] elem(int w, int k);
    if (w == 2) return 16'(k);
    return 16'hA000 | 16'(w << 8) | 16'(k);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int w = 0; w < 8; w++)
      for (int k = 0; k < NE; k++)
        mem[w][EW*k +: EW] = elem(w, k);
  end

  // One-cycle read latency memory
  initial forever begin
    @(posedge clk);
    if (m_en && m_rw) m_rdata <= mem[m_address];
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (bp_en) begin
      out_ready = bp_pat[0];
      bp_pat = {bp_pat[0], bp_pat[3:1]};
    end else begin
      out_ready = 1'b1;
    end
  end

  initial begin : monitor
    logic stalled;
    logic [EW-1:0] held;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid", out_valid, 1);
          check("stall_hold", out_data, held);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_elem: got %0h expected none", out_data);
          end else begin
            check("elem", out_data, exp_q.pop_front());
          end
        end
        if (out_valid) check("no_req_in_emit", bus_req, 0);
        if (m_en) begin
          check("en_has_gnt", bus_gnt, 1);
          check("m_rw_read", m_rw, 1);
          if (addr_exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_read: got addr %0d expected none", m_address);
          end else begin
            check("rd_addr", m_address, addr_exp_q.pop_front());
          end
        end
        stalled = out_valid && !out_ready;
        held = out_data;
        if (done) done_cnt++;
        if (bus_req) req_cnt++;
      end
    end
  end

  task automatic run(input int base, input int cnt);
    for (int w = 0; w < cnt; w++) begin
      addr_exp_q.push_back(AW'((base + w) % 8));
      for (int k = 0; k < NE; k++) exp_q.push_back(elem((base + w) % 8, k));
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = AW'(base);
    word_cnt = (AW + 1)'(cnt);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < max);
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done expected done within %0d", max);
    end
  endtask

  task automatic finish_run(string tag);
    repeat (2) @(negedge clk);
    check({tag, "_done_once"}, done_cnt, 1);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_elems_left"}, exp_q.size(), 0);
    check({tag, "_reads_left"}, addr_exp_q.size(), 0);
  endtask

  initial begin
    #1;
    check("rst_m_rw", m_rw, 1);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bus_req", bus_req, 0);
    check("rst_m_en", m_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_m_address", m_address, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;

    // single word, free-flowing: REQ, WAIT, 16 EMIT, DONE
    done_cnt = 0;
    run(2, 1);
    wait_done(100, n);
    check("single_latency", n, 19);
    finish_run("single");

    // address wrap 7 -> 0
    done_cnt = 0;
    run(7, 2);
    wait_done(200, n);
    check("wrap_latency", n, 37);
    finish_run("wrap");

    // backpressure pattern 1,0,0,1
    done_cnt = 0;
    bp_en = 1'b1;
    run(3, 1);
    wait_done(400, n);
    bp_en = 1'b0;
    finish_run("bp");

    // grant held low for five REQ cycles
    done_cnt = 0;
    @(posedge clk);
    #1;
    bus_gnt = 1'b0;
    run(5, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("gnt_wait_req", bus_req, 1);
      check("gnt_wait_en", m_en, 0);
    end
    @(posedge clk);
    #1;
    bus_gnt = 1'b1;
    @(negedge clk);
    check("gnt_read_issued", m_en, 1);
    wait_done(100, n);
    finish_run("gnt");

    // zero word count
    done_cnt = 0;
    req_cnt = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    word_cnt = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    @(negedge clk);
    check("zero_done_drop", done, 0);
    check("zero_no_req", req_cnt, 0);
    check("zero_done_once", done_cnt, 1);

    // second start mid-run is ignored
    done_cnt = 0;
    run(1, 1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 3'd4;
    word_cnt = 4'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(100, n);
    finish_run("ignore");

    // asynchronous reset during EMIT
    done_cnt = 0;
    run(6, 2);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ar_reached_emit", out_valid, 1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_busy", busy, 0);
    check("ar_bus_req", bus_req, 0);
    check("ar_m_en", m_en, 0);
    check("ar_out_data", out_data, 0);
    check("ar_done", done, 0);
    exp_q.delete();
    addr_exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("ar_no_done", done_cnt, 0);
    run(2, 1);
    wait_done(100, n);
    check("ar_restart_latency", n, 19);
    finish_run("ar");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1);
  end

endmodule
